// File: rtl/dct_axil_regbank.sv
// -----------------------------------------------------------------------------
// dct_axil_regbank
//
// AXI4-Lite slave register bank for the DCT kernel IP.
//   reg 0          CTRL   : bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN
//   reg 1          STATUS : bit0 BUSY (live kern_busy), bit1 DONE (W1C),
//                           bit2 REJ (START seen while busy, W1C)
//   reg 2..N-1     general-purpose byte-strobed config registers
// Indices >= NUM_REGS are unmapped: writes dropped, reads return 0, SLVERR.
//
// Optional feature macro: DCT_REGBANK_IRQ_EN
//   defined   -> irq port present, irq = registered (IRQ_EN & DONE)
//   undefined -> no irq port, IRQ_EN is plain storage
//
// Ports
//   ACLK, ARESET         clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*      AXI4-Lite write address / data / response channels
//   S_AXI_AR*/R*         AXI4-Lite read address / data channels
//   kern_start           one-cycle start pulse to the DCT core
//   kern_busy            DCT core busy level
//   kern_done            one-cycle completion pulse from the DCT core
//   irq                  level interrupt (DCT_REGBANK_IRQ_EN only)
//   cfg_regs             GP registers 2..NUM_REGS-1 flattened, reg 2 in LSBs
//
// Handshake rule used on every channel: a transfer happens on the rising edge
// where VALID and READY are both high; VALID/payload from this block stay
// stable until that edge, and READY never depends combinationally on VALID.
// -----------------------------------------------------------------------------
module dct_axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 8
) (
  input  logic                                           ACLK,
  input  logic                                           ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                  S_AXI_AWADDR,
  input  logic                                           S_AXI_AWVALID,
  output logic                                           S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                  S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                S_AXI_WSTRB,
  input  logic                                           S_AXI_WVALID,
  output logic                                           S_AXI_WREADY,
  output logic [1:0]                                     S_AXI_BRESP,
  output logic                                           S_AXI_BVALID,
  input  logic                                           S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                  S_AXI_ARADDR,
  input  logic                                           S_AXI_ARVALID,
  output logic                                           S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                  S_AXI_RDATA,
  output logic [1:0]                                     S_AXI_RRESP,
  output logic                                           S_AXI_RVALID,
  input  logic                                           S_AXI_RREADY,
  output logic                                           kern_start,
  input  logic                                           kern_busy,
  input  logic                                           kern_done,
`ifdef DCT_REGBANK_IRQ_EN
  output logic                                           irq,
`endif
  output logic [(NUM_REGS-2)*C_S_AXI_DATA_WIDTH-1:0]     cfg_regs
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IDXW     = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int NGP      = NUM_REGS - 2;
  localparam logic [IDXW:0] NUM_REGS_L  = (IDXW + 1)'(NUM_REGS);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  function automatic logic is_mapped(input logic [IDXW-1:0] idx);
    return {1'b0, idx} < NUM_REGS_L;
  endfunction

  // Ready gating: all READYs stay low until the first edge after reset release.
  logic rdy_en;

  // Write holding slots
  logic            aw_full;
  logic [IDXW-1:0] aw_idx;
  logic            w_full;
  logic [DW-1:0]   w_data;
  logic [SW-1:0]   w_strb;

  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          rvalid_q;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rdata_q;

  // Register storage
  logic          irq_en;
  logic          done;
  logic          rej;
  logic [DW-1:0] gp [NGP];

  logic aw_hs, w_hs, ar_hs, commit;
  logic [IDXW-1:0] wr_idx;
  logic [DW-1:0]   wr_data;
  logic [SW-1:0]   wr_strb;
  logic            wr_mapped, wr_ctrl, wr_stat, start_req;
  logic [IDXW-1:0] rd_idx;
  logic [DW-1:0]   rd_data;

  assign S_AXI_AWREADY = rdy_en & ~aw_full & ~bvalid_q;
  assign S_AXI_WREADY  = rdy_en & ~w_full & ~bvalid_q;
  assign S_AXI_ARREADY = rdy_en & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // A slot being filled this cycle forwards straight into the commit, so a
  // write commits on the same edge as its second handshake.
  assign commit  = (aw_full | aw_hs) & (w_full | w_hs);
  assign wr_idx  = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB] : aw_idx;
  assign wr_data = w_hs ? S_AXI_WDATA : w_data;
  assign wr_strb = w_hs ? S_AXI_WSTRB : w_strb;

  assign wr_mapped = is_mapped(wr_idx);
  assign wr_ctrl   = commit & (wr_idx == '0) & wr_strb[0];
  assign wr_stat   = commit & (wr_idx == IDXW'(1)) & wr_strb[0];
  assign start_req = wr_ctrl & wr_data[0];

  // Byte-offset address bits carry no information for a word-wide bank.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Channel state
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdy_en   <= 1'b0;
      aw_full  <= 1'b0;
      aw_idx   <= '0;
      w_full   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      rdy_en <= 1'b1;

      if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;

      if (commit) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_full <= 1'b1;
          aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
        end
        if (w_hs) begin
          w_full <= 1'b1;
          w_data <= S_AXI_WDATA;
          w_strb <= S_AXI_WSTRB;
        end
      end

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= is_mapped(rd_idx) ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Register file and kernel handshake
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      irq_en     <= 1'b0;
      done       <= 1'b0;
      rej        <= 1'b0;
      kern_start <= 1'b0;
      for (int i = 0; i < NGP; i++) gp[i] <= '0;
    end else begin
      kern_start <= start_req & ~kern_busy;
      if (wr_ctrl) irq_en <= wr_data[1];
      // Set terms come first so a hardware event beats a same-cycle clear.
      done <= kern_done | (done & ~(wr_stat & wr_data[1]));
      rej  <= (start_req & kern_busy) | (rej & ~(wr_stat & wr_data[2]));
      for (int i = 0; i < NGP; i++) begin
        if (commit && (wr_idx == IDXW'(i + 2))) begin
          for (int b = 0; b < SW; b++) begin
            if (wr_strb[b]) gp[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef DCT_REGBANK_IRQ_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) irq <= 1'b0;
    else        irq <= irq_en & done;
  end
`endif

  // Read mux sees pre-commit register contents, so a read racing a write to
  // the same register returns the old value.
  always_comb begin
    rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    rd_data = '0;
    if (rd_idx == '0) begin
      rd_data[1] = irq_en;
    end else if (rd_idx == IDXW'(1)) begin
      rd_data[0] = kern_busy;
      rd_data[1] = done;
      rd_data[2] = rej;
    end
    for (int i = 0; i < NGP; i++) begin
      if (rd_idx == IDXW'(i + 2)) rd_data = gp[i];
    end
  end

  for (genvar g = 0; g < NGP; g++) begin : g_cfg
    assign cfg_regs[g*DW +: DW] = gp[g];
  end

endmodule

// File: tb/tb_dct_axil_regbank.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for dct_axil_regbank (default parameters).
// Build with +define+DCT_REGBANK_IRQ_EN to also exercise the irq output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dct_axil_regbank;
  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int NR  = 8;
  localparam int NGP = NR - 2;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [AW-1:0]     S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [DW-1:0]     S_AXI_WDATA;
  logic [DW/8-1:0]   S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [AW-1:0]     S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [DW-1:0]     S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;
  logic              kern_start;
  logic              kern_busy;
  logic              kern_done;
`ifdef DCT_REGBANK_IRQ_EN
  logic              irq;
`endif
  logic [NGP*DW-1:0] cfg_regs;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int b_cnt = 0;
  logic start_at_b;
  logic [DW-1:0] exp_gp [NGP];

  dct_axil_regbank #(
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_REGS(NR)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .kern_start(kern_start), .kern_busy(kern_busy), .kern_done(kern_done),
`ifdef DCT_REGBANK_IRQ_EN
    .irq(irq),
`endif
    .cfg_regs(cfg_regs)
  );

  // ---------------- clock ----------------
  always #5 ACLK = ~ACLK;

  // Event counters sampled mid-cycle
  always @(negedge ACLK) begin
    if (kern_start === 1'b1) start_cnt++;
    if (S_AXI_BVALID === 1'b1) b_cnt++;
  end

  function automatic logic [NGP*DW-1:0] pack_exp();
    logic [NGP*DW-1:0] v;
    for (int i = 0; i < NGP; i++) v[i*DW +: DW] = exp_gp[i];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [DW/8-1:0] strb, input int aw_dly, input int w_dly,
                           output logic [1:0] resp);
    bit aw_done, w_done, aw_go, w_go;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; resp = 2'b11; start_at_b = 1'b0;
    S_AXI_BREADY = 1'b1;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (!aw_done && cyc >= aw_dly) S_AXI_AWVALID = 1'b1;
      if (!w_done && cyc >= w_dly)   S_AXI_WVALID  = 1'b1;
      @(negedge ACLK);
      aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
      w_go  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_go) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_go)  begin S_AXI_WVALID  = 1'b0; w_done  = 1; end
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      n_cmp++; n_bad++;
      $display("FAIL write_handshake addr=%h: timed out, aw=%0d w=%0d expected both", addr, aw_done, w_done);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    end else begin
      cyc = 0;
      @(negedge ACLK);
      while (S_AXI_BVALID !== 1'b1 && cyc < 50) begin @(negedge ACLK); cyc++; end
      if (S_AXI_BVALID !== 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL write_bvalid addr=%h: BVALID never rose, expected within 50 cycles", addr);
      end else begin
        resp = S_AXI_BRESP;
        start_at_b = kern_start;
      end
      @(posedge ACLK); #1;
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    bit go;
    int cyc;
    go = 0; cyc = 0; data = '1; resp = 2'b11;
    S_AXI_RREADY = 1'b1;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!go && cyc < 50) begin
      @(negedge ACLK);
      go = S_AXI_ARREADY;
      @(posedge ACLK); #1;
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    if (!go) begin
      n_cmp++; n_bad++;
      $display("FAIL read_handshake addr=%h: ARREADY never seen", addr);
    end else begin
      cyc = 0;
      @(negedge ACLK);
      while (S_AXI_RVALID !== 1'b1 && cyc < 50) begin @(negedge ACLK); cyc++; end
      if (S_AXI_RVALID !== 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL read_rvalid addr=%h: RVALID never rose", addr);
      end else begin
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
      end
      @(posedge ACLK); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DW-1:0] d; logic [1:0] r;
    repeat (3) @(posedge ACLK); #1;
    n_cmp++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin n_bad++;
      $display("FAIL reset_readys got=%b exp=000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
    n_cmp++; if ({S_AXI_BVALID, S_AXI_RVALID, kern_start} !== 3'b000) begin n_bad++;
      $display("FAIL reset_valids got=%b exp=000", {S_AXI_BVALID, S_AXI_RVALID, kern_start}); end
    n_cmp++; if (cfg_regs !== '0) begin n_bad++;
      $display("FAIL reset_cfg got=%h exp=0", cfg_regs); end
    ARESET = 1'b0; #1;
    n_cmp++; if (S_AXI_AWREADY !== 1'b0) begin n_bad++;
      $display("FAIL ready_before_edge got=%b exp=0", S_AXI_AWREADY); end
    @(posedge ACLK); #1;
    n_cmp++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin n_bad++;
      $display("FAIL ready_after_edge got=%b exp=111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
    for (int i = 0; i < 2; i++) begin
      axi_read(AW'(i * 4), d, r);
      n_cmp++; if ({r, d} !== {2'b00, 32'h0}) begin n_bad++;
        $display("FAIL reset_reg%0d got=%h/%b exp=0/00", i, d, r); end
    end
  endtask

  task automatic test_gp_rw();
    logic [DW-1:0] d; logic [1:0] r;
    for (int i = 0; i < NGP; i++) begin
      axi_write(AW'((i + 2) * 4), 32'hA5A5_0001 + DW'(i), 4'hF, 0, 0, r);
      exp_gp[i] = 32'hA5A5_0001 + DW'(i);
      n_cmp++; if (r !== 2'b00) begin n_bad++; $display("FAIL gp_bresp reg%0d got=%b exp=00", i + 2, r); end
    end
    for (int i = 0; i < NGP; i++) begin
      axi_read(AW'((i + 2) * 4), d, r);
      n_cmp++; if ({r, d} !== {2'b00, exp_gp[i]}) begin n_bad++;
        $display("FAIL gp_read reg%0d got=%h/%b exp=%h/00", i + 2, d, r, exp_gp[i]); end
    end
    n_cmp++; if (cfg_regs !== pack_exp()) begin n_bad++;
      $display("FAIL gp_cfg got=%h exp=%h", cfg_regs, pack_exp()); end
  endtask

  task automatic test_strobe();
    logic [DW-1:0] d; logic [1:0] r;
    axi_write(6'h0C, 32'h0, 4'hF, 0, 0, r);
    axi_write(6'h0C, 32'hFFFF_FFFF, 4'b0010, 0, 0, r);
    axi_read(6'h0C, d, r);
    n_cmp++; if (d !== 32'h0000_FF00) begin n_bad++; $display("FAIL strobe_lane1 got=%h exp=0000ff00", d); end
    axi_write(6'h0C, 32'h1234_5678, 4'b1001, 0, 0, r);
    axi_read(6'h0C, d, r);
    n_cmp++; if (d !== 32'h1200_FF78) begin n_bad++; $display("FAIL strobe_lane03 got=%h exp=1200ff78", d); end
    exp_gp[1] = 32'h1200_FF78;
    n_cmp++; if (cfg_regs !== pack_exp()) begin n_bad++;
      $display("FAIL strobe_cfg got=%h exp=%h", cfg_regs, pack_exp()); end
  endtask

  task automatic test_skew();
    logic [DW-1:0] d; logic [1:0] r; int bc0;
    bc0 = b_cnt;
    axi_write(6'h10, 32'hDEAD_0004, 4'hF, 0, 3, r);
    repeat (4) @(posedge ACLK); #1;
    n_cmp++; if (b_cnt - bc0 !== 1) begin n_bad++; $display("FAIL skew_aw_first_bcount got=%0d exp=1", b_cnt - bc0); end
    axi_read(6'h10, d, r);
    n_cmp++; if ({r, d} !== {2'b00, 32'hDEAD_0004}) begin n_bad++;
      $display("FAIL skew_aw_first_data got=%h/%b exp=dead0004/00", d, r); end
    bc0 = b_cnt;
    axi_write(6'h14, 32'hBEEF_0005, 4'hF, 3, 0, r);
    repeat (4) @(posedge ACLK); #1;
    n_cmp++; if (b_cnt - bc0 !== 1) begin n_bad++; $display("FAIL skew_w_first_bcount got=%0d exp=1", b_cnt - bc0); end
    axi_read(6'h14, d, r);
    n_cmp++; if ({r, d} !== {2'b00, 32'hBEEF_0005}) begin n_bad++;
      $display("FAIL skew_w_first_data got=%h/%b exp=beef0005/00", d, r); end
    exp_gp[2] = 32'hDEAD_0004; exp_gp[3] = 32'hBEEF_0005;
  endtask

  task automatic test_kernel();
    logic [DW-1:0] d; logic [1:0] r; int c0;
    kern_busy = 1'b0;
    c0 = start_cnt;
    axi_write(6'h00, 32'h3, 4'hF, 0, 0, r);
    n_cmp++; if (start_at_b !== 1'b1) begin n_bad++; $display("FAIL start_with_bvalid got=%b exp=1", start_at_b); end
    repeat (3) @(posedge ACLK); #1;
    n_cmp++; if (start_cnt - c0 !== 1) begin n_bad++; $display("FAIL start_pulse_len got=%0d exp=1", start_cnt - c0); end
    axi_read(6'h00, d, r);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL ctrl_read got=%h exp=2", d); end
    kern_done = 1'b1; @(posedge ACLK); #1; kern_done = 1'b0;
    axi_read(6'h04, d, r);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL status_done got=%h exp=2", d); end
`ifdef DCT_REGBANK_IRQ_EN
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set got=%b exp=1", irq); end
`endif
    axi_write(6'h04, 32'h2, 4'hF, 0, 0, r);
    axi_read(6'h04, d, r);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL status_w1c got=%h exp=0", d); end
`ifdef DCT_REGBANK_IRQ_EN
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear got=%b exp=0", irq); end
`endif
    kern_busy = 1'b1;
    c0 = start_cnt;
    axi_write(6'h00, 32'h1, 4'hF, 0, 0, r);
    repeat (3) @(posedge ACLK); #1;
    n_cmp++; if (start_cnt - c0 !== 0) begin n_bad++; $display("FAIL start_rejected got=%0d exp=0", start_cnt - c0); end
    axi_read(6'h04, d, r);
    n_cmp++; if (d !== 32'h5) begin n_bad++; $display("FAIL status_rej got=%h exp=5", d); end
    kern_busy = 1'b0;
    axi_write(6'h04, 32'h4, 4'hF, 0, 0, r);
    axi_read(6'h04, d, r);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rej_w1c got=%h exp=0", d); end
  endtask

  task automatic test_unmapped();
    logic [DW-1:0] d; logic [1:0] r;
    axi_write(6'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
    n_cmp++; if (r !== 2'b10) begin n_bad++; $display("FAIL unmapped_bresp got=%b exp=10", r); end
    axi_read(6'h20, d, r);
    n_cmp++; if ({r, d} !== {2'b10, 32'h0}) begin n_bad++;
      $display("FAIL unmapped_read20 got=%h/%b exp=0/10", d, r); end
    axi_read(6'h3C, d, r);
    n_cmp++; if ({r, d} !== {2'b10, 32'h0}) begin n_bad++;
      $display("FAIL unmapped_read3c got=%h/%b exp=0/10", d, r); end
    n_cmp++; if (cfg_regs !== pack_exp()) begin n_bad++;
      $display("FAIL unmapped_cfg got=%h exp=%h", cfg_regs, pack_exp()); end
    axi_read(6'h00, d, r);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_ctrl got=%h exp=0", d); end
  endtask

  task automatic test_back_to_back();
    int ar_n, r_n;
    ar_n = 0; r_n = 0;
    S_AXI_RREADY = 1'b1;
    S_AXI_ARADDR = 6'h08; S_AXI_ARVALID = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) ar_n++;
      if (S_AXI_RVALID) begin
        r_n++;
        n_cmp++; if (S_AXI_RDATA !== exp_gp[0]) begin n_bad++;
          $display("FAIL b2b_data got=%h exp=%h", S_AXI_RDATA, exp_gp[0]); end
      end
    end
    @(posedge ACLK); #1; S_AXI_ARVALID = 1'b0;
    n_cmp++; if ({ar_n, r_n} !== {32'd4, 32'd4}) begin n_bad++;
      $display("FAIL b2b_rate got ar=%0d r=%0d exp=4/4", ar_n, r_n); end
    repeat (2) @(posedge ACLK); #1;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d; logic [1:0] r; int bc0;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    S_AXI_AWADDR = 6'h18; S_AXI_WDATA = 32'h6666_6666; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 6'h08; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1; S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    n_cmp++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11) begin n_bad++;
      $display("FAIL stall_setup got=%b exp=11", {S_AXI_BVALID, S_AXI_RVALID}); end
    ARESET = 1'b1; #1;
    n_cmp++; if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY} !== 3'b000) begin n_bad++;
      $display("FAIL midreset_valids got=%b exp=000", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY}); end
    n_cmp++; if ({cfg_regs, S_AXI_RDATA} !== '0) begin n_bad++;
      $display("FAIL midreset_regs cfg=%h rdata=%h exp=0", cfg_regs, S_AXI_RDATA); end
    for (int i = 0; i < NGP; i++) exp_gp[i] = '0;
    @(posedge ACLK); #1; ARESET = 1'b0;
    bc0 = b_cnt;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    repeat (4) @(posedge ACLK); #1;
    n_cmp++; if (b_cnt !== bc0 || S_AXI_RVALID !== 1'b0) begin n_bad++;
      $display("FAIL no_stale_resp got b=%0d rvalid=%b exp=0/0", b_cnt - bc0, S_AXI_RVALID); end
    axi_read(6'h04, d, r);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL midreset_status got=%h exp=0", d); end
    axi_write(6'h08, 32'h5A5A_5A5A, 4'hF, 0, 0, r);
    n_cmp++; if (r !== 2'b00) begin n_bad++; $display("FAIL post_reset_bresp got=%b exp=00", r); end
    exp_gp[0] = 32'h5A5A_5A5A;
    axi_read(6'h08, d, r);
    n_cmp++; if (d !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL post_reset_read got=%h exp=5a5a5a5a", d); end
    n_cmp++; if (cfg_regs !== pack_exp()) begin n_bad++;
      $display("FAIL post_reset_cfg got=%h exp=%h", cfg_regs, pack_exp()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    kern_busy = 1'b0; kern_done = 1'b0;
    for (int i = 0; i < NGP; i++) exp_gp[i] = '0;
    test_reset();
    test_gp_rw();
    test_strobe();
    test_skew();
    test_kernel();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
